fibo_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares one `fibonacci_calculator` instance between `NUM_REQ` requesters. It accepts one request at a time and owns the calculator's reset and `begin_fibo` pins. It returns each result, tagged with the requester's ID, on a single valid/ready response port. It sits between the request sources and the calculator and is the only block that drives the calculator's inputs.

---
 rtl/fibo_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/fibo_scheduler.sv | 159 +++++++++++++++
 tb/tb_fibo_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_sched_pkg.sv
// Shared types and constants for the Fibonacci calculator scheduler.
package fibo_sched_pkg;

  localparam int FIBO_MAX_N = 24;  // F(25) no longer fits in 16 bits
  localparam int FIBO_W     = 16;
  localparam int IDX_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CRST,
    SETTLE,
    START,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at an internal
// pointer, which advances past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fibo_scheduler.sv
// Shares one Fibonacci calculator between NUM_REQ requesters: round-robin
// grant, calculator reset/begin sequencing, and an ID-tagged response port.
module fibo_scheduler
  import fibo_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int BEGIN_CYCLES  = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*5-1:0]       req_n,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [15:0]                resp_value,
  output logic                       resp_err,
  output logic                       calc_reset_n,
  output logic [4:0]                 calc_input_s,
  output logic                       calc_begin_fibo,
  input  logic [15:0]                calc_fibo_out,
  input  logic                       calc_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RST_CYCLES + SETTLE_CYCLES + BEGIN_CYCLES + TIMEOUT + 1);

  sched_state_t      state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ID_W-1:0]   job_id, job_id_d;
  logic [IDX_W-1:0]  job_n, job_n_d;
  logic [NUM_REQ-1:0] req_ready_d, grant;
  logic [ID_W-1:0]   grant_id;
  logic              resp_valid_d, resp_err_d;
  logic [ID_W-1:0]   resp_id_d;
  logic [FIBO_W-1:0] resp_value_d;
  logic              calc_reset_n_d, calc_begin_fibo_d;
  logic [IDX_W-1:0]  calc_input_s_d;
  logic              arb_en;

  // ARB spends one cycle choosing (req_ready still low) and one pulsing the grant.
  assign arb_en = (state == ARB) && (req_ready == '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_valid),
    .enable   (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + 1'b1;
    job_id_d     = job_id;
    job_n_d      = job_n;
    req_ready_d  = '0;
    resp_valid_d = resp_valid;
    resp_id_d    = resp_id;
    resp_value_d = resp_value;
    resp_err_d   = resp_err;

    case (state)
      IDLE: if (|req_valid) state_d = ARB;

      ARB: begin
        if (req_ready == '0) begin
          if (|grant) begin
            req_ready_d = grant;
            job_id_d    = grant_id;
            job_n_d     = req_n[int'(grant_id)*IDX_W +: IDX_W];
          end else begin
            state_d = IDLE;
          end
        end else if (job_n > IDX_W'(FIBO_MAX_N)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = job_id;
          resp_value_d = '0;
          resp_err_d   = 1'b1;
        end else begin
          state_d = CRST;
        end
      end

      CRST:   if (cnt == CNT_W'(RST_CYCLES - 1))    state_d = SETTLE;
      SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_d = START;
      START:  if (cnt == CNT_W'(BEGIN_CYCLES - 1))  state_d = WAIT;

      WAIT: begin
        if (calc_done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = job_id;
          resp_value_d = calc_fibo_out;
          resp_err_d   = 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = job_id;
          resp_value_d = '0;
          resp_err_d   = 1'b1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = (|req_valid) ? ARB : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != state) cnt_d = '0;

    // Calculator pins are registered from the next state so they line up with it.
    calc_reset_n_d    = (state_d inside {SETTLE, START, WAIT});
    calc_begin_fibo_d = (state_d == START);
    calc_input_s_d    = calc_reset_n_d ? job_n_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      job_id          <= '0;
      job_n           <= '0;
      req_ready       <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= '0;
      resp_value      <= '0;
      resp_err        <= 1'b0;
      calc_reset_n    <= 1'b0;
      calc_input_s    <= '0;
      calc_begin_fibo <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      job_id          <= job_id_d;
      job_n           <= job_n_d;
      req_ready       <= req_ready_d;
      resp_valid      <= resp_valid_d;
      resp_id         <= resp_id_d;
      resp_value      <= resp_value_d;
      resp_err        <= resp_err_d;
      calc_reset_n    <= calc_reset_n_d;
      calc_input_s    <= calc_input_s_d;
      calc_begin_fibo <= calc_begin_fibo_d;
    end
  end

endmodule

// File: tb/tb_fibo_scheduler.sv
// Directed bench for fibo_scheduler with a behavioural calculator model.
module tb_fibo_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*5-1:0] req_n = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [ID_W-1:0]      resp_id;
  logic [15:0]          resp_value;
  logic                 resp_err;
  logic                 calc_reset_n;
  logic [4:0]           calc_input_s;
  logic                 calc_begin_fibo;
  logic [15:0]          calc_fibo_out = '0;
  logic                 calc_done = 1'b0;

  fibo_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_n           (req_n),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_value      (resp_value),
    .resp_err        (resp_err),
    .calc_reset_n    (calc_reset_n),
    .calc_input_s    (calc_input_s),
    .calc_begin_fibo (calc_begin_fibo),
    .calc_fibo_out   (calc_fibo_out),
    .calc_done       (calc_done)
  );

  always #5 clk = ~clk;

  // Calculator model: done a few cycles after begin, sticky until reset.
  logic       calc_hang = 1'b0;
  logic       busy = 1'b0;
  logic [2:0] lat = '0;

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (!calc_reset_n) begin
      calc_done     <= 1'b0;
      calc_fibo_out <= '0;
      busy          <= 1'b0;
      lat           <= '0;
    end else if (calc_begin_fibo && !busy && !calc_done) begin
      busy <= 1'b1;
      lat  <= '0;
    end else if (busy && !calc_hang) begin
      if (lat == 3'd3) begin
        calc_done     <= 1'b1;
        calc_fibo_out <= fib(calc_input_s);
        busy          <= 1'b0;
      end else begin
        lat <= lat + 3'd1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_id_q[$], grant_cyc_q[$];
  int rsp_id_q[$], rsp_val_q[$], rsp_err_q[$];
  int rise_q[$];
  int begin_cnt, begin_first, done_first, rst_hi_cnt;
  logic prev_rv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    grant_id_q.delete(); grant_cyc_q.delete();
    rsp_id_q.delete(); rsp_val_q.delete(); rsp_err_q.delete(); rise_q.delete();
    begin_cnt = 0; begin_first = -1; done_first = -1; rst_hi_cnt = 0;
  endtask

  // One clock: log handshakes of the current cycle, advance, then observe.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    acc = req_valid & req_ready;
    if (resp_valid && resp_ready) begin
      rsp_id_q.push_back(int'(resp_id));
      rsp_val_q.push_back(int'(resp_value));
      rsp_err_q.push_back(int'(resp_err));
    end
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~acc;
    if (req_ready != '0) begin
      check("grant_onehot", $countones(req_ready), 1);
      check("grant_during_resp", resp_valid, 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i]) begin
          grant_id_q.push_back(i);
          grant_cyc_q.push_back(cyc);
        end
    end
    if (calc_begin_fibo) begin
      begin_cnt++;
      if (begin_first < 0) begin_first = cyc;
    end
    if (calc_done && done_first < 0) done_first = cyc;
    if (calc_reset_n) rst_hi_cnt++;
    if (resp_valid && !prev_rv) rise_q.push_back(cyc);
    prev_rv = resp_valid;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_value"}, resp_value, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_calc_reset_n"}, calc_reset_n, 0);
    check({tag, "_calc_input_s"}, calc_input_s, 0);
    check({tag, "_calc_begin"}, calc_begin_fibo, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    calc_hang = 1'b0;
    tick();
    tick();
    check_reset_outputs(tag);
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_resps(input int k, input int budget, input string tag);
    int n = 0;
    while (rsp_id_q.size() < k && n < budget) begin
      tick();
      n++;
    end
    check(tag, rsp_id_q.size(), k);
  endtask

  task automatic check_rsp(input int i, input int id, input int val, input int err);
    if (rsp_id_q.size() > i) begin
      check($sformatf("rsp%0d_id", i), rsp_id_q[i], id);
      check($sformatf("rsp%0d_value", i), rsp_val_q[i], val);
      check($sformatf("rsp%0d_err", i), rsp_err_q[i], err);
    end else begin
      check($sformatf("rsp%0d_missing", i), rsp_id_q.size(), i + 1);
    end
  endtask

  initial begin
    int t, r, n;
    clear_logs();

    // Single request, n=5
    do_reset("rst1");
    req_n[4:0] = 5'd5;
    req_valid  = 4'b0001;
    run_until_resps(1, 200, "t1_done");
    check_rsp(0, 0, 5, 0);
    check("t1_begin_cycles", begin_cnt, 2);
    if (grant_cyc_q.size() > 0 && rise_q.size() > 0 && done_first >= 0) begin
      t = grant_cyc_q[0];
      check("t1_begin_at", begin_first, t + 5);
      check("t1_resp_after_done", rise_q[0], done_first + 1);
    end else check("t1_events", 0, 1);

    // Four simultaneous requests
    do_reset("rst2");
    req_n     = {5'd0, 5'd1, 5'd12, 5'd9};
    req_valid = 4'b1111;
    run_until_resps(4, 400, "t2_done");
    for (int i = 0; i < 4; i++) begin
      if (grant_id_q.size() > i) check($sformatf("t2_grant%0d", i), grant_id_q[i], i);
      else check($sformatf("t2_grant%0d_missing", i), grant_id_q.size(), i + 1);
    end
    check_rsp(0, 0, 34, 0);
    check_rsp(1, 1, 144, 0);
    check_rsp(2, 2, 1, 0);
    check_rsp(3, 3, 0, 0);

    // Out-of-range indices
    do_reset("rst3");
    req_n[4:0] = 5'd25;
    req_n[9:5] = 5'd31;
    req_valid  = 4'b0011;
    run_until_resps(2, 100, "t3_done");
    check_rsp(0, 0, 0, 1);
    check_rsp(1, 1, 0, 1);
    if (grant_cyc_q.size() == 2 && rise_q.size() == 2) begin
      check("t3_lat0", rise_q[0], grant_cyc_q[0] + 1);
      check("t3_lat1", rise_q[1], grant_cyc_q[1] + 1);
    end else check("t3_events", 0, 1);
    check("t3_calc_reset_high", rst_hi_cnt, 0);

    // Calculator timeout, then recovery
    do_reset("rst4");
    calc_hang  = 1'b1;
    req_n[4:0] = 5'd7;
    req_valid  = 4'b0001;
    run_until_resps(1, 200, "t4_done");
    check_rsp(0, 0, 0, 1);
    if (grant_cyc_q.size() > 0 && rise_q.size() > 0)
      check("t4_timeout_at", rise_q[0], grant_cyc_q[0] + 7 + 64);
    else check("t4_events", 0, 1);
    calc_hang    = 1'b0;
    req_n[14:10] = 5'd7;
    req_valid    = 4'b0100;
    run_until_resps(2, 200, "t4_recover");
    check_rsp(1, 2, 13, 0);

    // Response back-pressure with a pending request
    do_reset("rst5");
    resp_ready = 1'b0;
    req_n[4:0] = 5'd5;
    req_n[9:5] = 5'd6;
    req_valid  = 4'b0011;
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    check("t5_resp_seen", resp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_stall_valid", resp_valid, 1);
      check("t5_stall_value", resp_value, 5);
      check("t5_stall_id", resp_id, 0);
      check("t5_stall_err", resp_err, 0);
    end
    check("t5_no_grant", grant_id_q.size(), 1);
    resp_ready = 1'b1;
    r = cyc;
    run_until_resps(2, 200, "t5_done");
    if (grant_cyc_q.size() == 2) check("t5_regrant_at", grant_cyc_q[1], r + 2);
    else check("t5_grants", grant_cyc_q.size(), 2);
    check_rsp(0, 0, 5, 0);
    check_rsp(1, 1, 8, 0);

    // Reset during WAIT, then a fresh job
    do_reset("rst6");
    req_n[4:0] = 5'd12;
    req_valid  = 4'b0001;
    n = 0;
    while (grant_cyc_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    check("t6_granted", grant_cyc_q.size(), 1);
    n = 0;
    while (cyc < grant_cyc_q[0] + 8 && n < 50) begin
      tick();
      n++;
    end
    check("t6_wait_input", calc_input_s, 12);
    check("t6_wait_calc_rst", calc_reset_n, 1);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("t6_mid");
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("t6_no_resp", rsp_id_q.size(), 0);
    check("t6_no_valid", rise_q.size(), 0);
    req_n[19:15] = 5'd12;
    req_valid    = 4'b1000;
    run_until_resps(1, 200, "t6_fresh");
    check_rsp(0, 3, 144, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
